// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and state encoding for the UART boot loader.
//   LOADER_MAGIC : frame start byte
//   LOADER_ACK   : response byte for a good frame
//   LOADER_NAK   : response byte for a failed frame
//   state_t      : loader FSM state encoding
package uart_boot_loader_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam logic [7:0] LOADER_ACK   = 8'h06;
    localparam logic [7:0] LOADER_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_RESP   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/loader_word_packer.sv
// Packs a stream of bytes, MSB first, into 32-bit words.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : restart packing at byte 0 of a new word
//   byte_valid   : byte_data is consumed this cycle
//   byte_data    : incoming byte
//   byte_idx     : position (0..3) the next byte will take in the word
//   word         : shift register; holds the complete word when word_valid is high
//   word_valid   : one-cycle strobe, the cycle after the 4th byte of a word
module loader_word_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_idx,
    output logic [31:0] word,
    output logic        word_valid
);

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else if (clear) begin
            byte_idx   <= 2'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (byte_idx == 2'd3);
            if (byte_valid) begin
                word     <= {word[23:0], byte_data};
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image, writes it word by word
// into instruction memory, holds the CPU until a load succeeds and answers
// each frame with ACK/NAK.
// Build option: define LOADER_CHECKSUM_EN to append and check a mod-256
// checksum byte over the data bytes.
// Ports:
//   clock, reset           : system clock, synchronous active-high reset
//   rx_data, rx_valid      : received byte and its one-cycle strobe
//   tx_data, tx_valid      : response byte, held until tx_ready
//   tx_ready               : transmitter accepts the response
//   imem_we/addr/wdata     : instruction-memory write port
//   cpu_hold               : processor stall request
//   load_done, load_error  : result of the last frame
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | wait for MAGIC, cpu held
// ST_LEN_HI | capture word count high byte
// ST_LEN_LO | capture word count low byte, range check
// ST_DATA   | pack data bytes, write words
// ST_CSUM   | compare checksum byte (checksum build only)
// ST_RESP   | present ACK/NAK until accepted
// ST_DONE   | load finished, cpu released, wait for MAGIC
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   MAX_WORDS  = 32'd1 << ADDR_WIDTH;

    state_t        state, state_n;
    logic [7:0]    tx_data_n;
    logic          tx_valid_n, cpu_hold_n, load_done_n, load_error_n;
    logic          go_ack, go_nak, payload_done;

    logic [15:0]   n_words;
    logic [15:0]   word_cnt;
    logic [TW-1:0] timer;
    logic [1:0]    byte_idx;

    logic          magic_accept, frame_state, data_byte, timeout;
    logic [15:0]   len_full;
    logic          len_too_big, last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign magic_accept = (state == ST_IDLE || state == ST_DONE) && rx_valid && (rx_data == LOADER_MAGIC);
    assign frame_state  = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA) || (state == ST_CSUM);
    assign data_byte    = (state == ST_DATA) && rx_valid;
    // An arriving byte always beats an expiring timer.
    assign timeout      = !rx_valid && (timer == '0);
    assign len_full     = {n_words[15:8], rx_data};
    assign len_too_big  = {16'd0, len_full} > MAX_WORDS;
    assign last_word    = (word_cnt == n_words - 16'd1);

    loader_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (magic_accept),
        .byte_valid (data_byte),
        .byte_data  (rx_data),
        .byte_idx   (byte_idx),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            cpu_hold   <= cpu_hold_n;
            load_done  <= load_done_n;
            load_error <= load_error_n;
        end
    end

    always_comb begin
        state_n      = state;
        tx_data_n    = tx_data;
        tx_valid_n   = tx_valid;
        cpu_hold_n   = cpu_hold;
        load_done_n  = load_done;
        load_error_n = load_error;
        go_ack       = 1'b0;
        go_nak       = 1'b0;
        payload_done = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (magic_accept) begin
                    state_n      = ST_LEN_HI;
                    cpu_hold_n   = 1'b1;
                    load_done_n  = 1'b0;
                    load_error_n = 1'b0;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid)     state_n = ST_LEN_LO;
                else if (timeout) go_nak  = 1'b1;
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    if (len_too_big)         go_nak       = 1'b1;
                    else if (len_full == 0)  payload_done = 1'b1;
                    else                     state_n      = ST_DATA;
                end else if (timeout) begin
                    go_nak = 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    if (byte_idx == 2'd3 && last_word) payload_done = 1'b1;
                end else if (timeout) begin
                    go_nak = 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum) go_ack = 1'b1;
                    else                 go_nak = 1'b1;
                end else if (timeout) begin
                    go_nak = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    if (tx_data == LOADER_ACK) begin
                        state_n     = ST_DONE;
                        load_done_n = 1'b1;
                        cpu_hold_n  = 1'b0;
                    end else begin
                        state_n      = ST_IDLE;
                        load_error_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (payload_done) begin
`ifdef LOADER_CHECKSUM_EN
            state_n = ST_CSUM;
`else
            go_ack = 1'b1;
`endif
        end

        if (go_ack || go_nak) begin
            state_n    = ST_RESP;
            tx_valid_n = 1'b1;
            tx_data_n  = go_ack ? LOADER_ACK : LOADER_NAK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_words   <= 16'd0;
            word_cnt  <= 16'd0;
            timer     <= TIMER_LOAD;
            imem_addr <= '0;
        end else begin
            if (magic_accept) begin
                word_cnt <= 16'd0;
                timer    <= TIMER_LOAD;
            end else if (frame_state) begin
                if (rx_valid)          timer <= TIMER_LOAD;
                else if (timer != '0)  timer <= timer - 1'b1;
            end
            if (state == ST_LEN_HI && rx_valid) n_words[15:8] <= rx_data;
            if (state == ST_LEN_LO && rx_valid) n_words[7:0]  <= rx_data;
            // Address is latched with the 4th byte so it lines up with the
            // packer's write strobe one cycle later.
            if (data_byte && byte_idx == 2'd3) begin
                imem_addr <= word_cnt[ADDR_WIDTH-1:0];
                word_cnt  <= word_cnt + 16'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset)             csum <= 8'd0;
        else if (magic_accept) csum <= 8'd0;
        else if (data_byte)    csum <= csum + rx_data;
    end
`endif

endmodule
